// File: rtl/mobilenet_v1_pkg.sv
// Shared definitions for the MobileNet-v1 accelerator: skip-fill FSM states,
// the default fill byte and the ceiling divide also used by the network controller.
package mobilenet_v1_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } skip_fill_state_t;

  localparam logic [7:0] FILL_VALUE = 8'h00;

  // Written as quotient plus remainder flag so num near 2^32 cannot overflow.
  function automatic logic [31:0] ceil_div(input logic [31:0] num, input logic [31:0] den);
    if (den == 32'd0) begin
      return 32'd0;
    end
    return (num / den) + ((num % den) != 32'd0 ? 32'd1 : 32'd0);
  endfunction

endpackage

// File: rtl/tile_skip_fill_if.sv
// Output feature-map write port: one LANES-byte beat per valid/ready handshake.
interface tile_skip_fill_if #(
  parameter int ADDR_W = 32,
  parameter int LANES  = 8
) ();

  logic                 wr_valid;
  logic                 wr_ready;
  logic [ADDR_W-1:0]    wr_addr;
  logic [8*LANES-1:0]   wr_data;
  logic [LANES-1:0]     wr_strb;

  modport master (
    output wr_valid,
    output wr_addr,
    output wr_data,
    output wr_strb,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_addr,
    input  wr_data,
    input  wr_strb,
    output wr_ready
  );

endinterface

// File: rtl/tile_skip_fill_addr_gen.sv
// Row/column/beat walker for the skip fill: keeps running addresses so that
// stepping through the tile needs only adds, advancing once per accepted beat.
module skip_fill_addr_gen #(
  parameter int DIM_W  = 16,
  parameter int ADDR_W = 32,
  parameter int LANES  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              advance,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] row_stride,
  input  logic [ADDR_W-1:0] pix_stride,
  input  logic [DIM_W-1:0]  tile_h,
  input  logic [DIM_W-1:0]  tile_w,
  input  logic [DIM_W-1:0]  beats_per_pix,
  output logic [ADDR_W-1:0] addr,
  output logic              beat_last,
  output logic              tile_last
);

  logic [DIM_W-1:0]  row_cnt_reg, row_cnt_next;
  logic [DIM_W-1:0]  col_cnt_reg, col_cnt_next;
  logic [DIM_W-1:0]  beat_cnt_reg, beat_cnt_next;
  logic [DIM_W-1:0]  h_reg, w_reg, beats_reg;
  logic [ADDR_W-1:0] row_stride_reg, pix_stride_reg;
  logic [ADDR_W-1:0] row_base_reg, row_base_next;
  logic [ADDR_W-1:0] pix_base_reg, pix_base_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic              col_last;
  logic              row_last;

  assign beat_last = (beat_cnt_reg == beats_reg - DIM_W'(1));
  assign col_last  = (col_cnt_reg == w_reg - DIM_W'(1));
  assign row_last  = (row_cnt_reg == h_reg - DIM_W'(1));
  assign tile_last = beat_last && col_last && row_last;
  assign addr      = addr_reg;

  always_comb begin
    row_cnt_next  = row_cnt_reg;
    col_cnt_next  = col_cnt_reg;
    beat_cnt_next = beat_cnt_reg;
    row_base_next = row_base_reg;
    pix_base_next = pix_base_reg;
    addr_next     = addr_reg;
    if (load) begin
      row_cnt_next  = '0;
      col_cnt_next  = '0;
      beat_cnt_next = '0;
      row_base_next = start_addr;
      pix_base_next = start_addr;
      addr_next     = start_addr;
    end else if (advance) begin
      if (!beat_last) begin
        beat_cnt_next = beat_cnt_reg + DIM_W'(1);
        addr_next     = addr_reg + ADDR_W'(LANES);
      end else if (!col_last) begin
        beat_cnt_next = '0;
        col_cnt_next  = col_cnt_reg + DIM_W'(1);
        pix_base_next = pix_base_reg + pix_stride_reg;
        addr_next     = pix_base_reg + pix_stride_reg;
      end else begin
        // Row wrap: next pixel starts from the row base, not the last pixel.
        beat_cnt_next = '0;
        col_cnt_next  = '0;
        row_cnt_next  = row_cnt_reg + DIM_W'(1);
        row_base_next = row_base_reg + row_stride_reg;
        pix_base_next = row_base_reg + row_stride_reg;
        addr_next     = row_base_reg + row_stride_reg;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_cnt_reg    <= '0;
      col_cnt_reg    <= '0;
      beat_cnt_reg   <= '0;
      h_reg          <= '0;
      w_reg          <= '0;
      beats_reg      <= '0;
      row_stride_reg <= '0;
      pix_stride_reg <= '0;
      row_base_reg   <= '0;
      pix_base_reg   <= '0;
      addr_reg       <= '0;
    end else begin
      row_cnt_reg  <= row_cnt_next;
      col_cnt_reg  <= col_cnt_next;
      beat_cnt_reg <= beat_cnt_next;
      row_base_reg <= row_base_next;
      pix_base_reg <= pix_base_next;
      addr_reg     <= addr_next;
      if (load) begin
        h_reg          <= tile_h;
        w_reg          <= tile_w;
        beats_reg      <= beats_per_pix;
        row_stride_reg <= row_stride;
        pix_stride_reg <= pix_stride;
      end
    end
  end

endmodule

// File: rtl/tile_skip_fill.sv
// Tile-skip responder: fills a masked-off output tile with cfg_fill_value and pulses skip_done.
// Define TILE_SKIP_FILL_STATS_EN to add saturating stat_tiles / stat_beats counters.
module tile_skip_fill
  import mobilenet_v1_pkg::*;
#(
  parameter int DIM_W  = 16,
  parameter int ADDR_W = 32,
  parameter int LANES  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               skip_start,
  output logic               skip_done,
  output logic               busy,
  input  logic [DIM_W-1:0]   tile_out_row,
  input  logic [DIM_W-1:0]   tile_out_col,
  input  logic [DIM_W-1:0]   tile_out_h,
  input  logic [DIM_W-1:0]   tile_out_w,
  input  logic [DIM_W-1:0]   cur_out_w,
  input  logic [DIM_W-1:0]   cur_out_c,
  input  logic [ADDR_W-1:0]  out_base_addr,
  input  logic [7:0]         cfg_fill_value,
  tile_skip_fill_if.master   wr
`ifdef TILE_SKIP_FILL_STATS_EN
  ,
  output logic [31:0]        stat_tiles,
  output logic [31:0]        stat_beats
`endif
);

  skip_fill_state_t state_reg, state_next;

  logic [ADDR_W-1:0] base_reg;
  logic [DIM_W-1:0]  row_reg, col_reg, h_reg, w_reg, cw_reg, c_reg;
  logic [7:0]        fill_reg;
  logic [LANES-1:0]  last_strb_reg;

  logic [ADDR_W-1:0] row_stride;
  logic [ADDR_W-1:0] pix_stride;
  logic [ADDR_W-1:0] start_addr;
  logic [DIM_W-1:0]  beats_per_pix;
  logic [DIM_W-1:0]  c_rem;
  logic [LANES-1:0]  last_strb_calc;
  logic              zero_tile;
  logic              fire;
  logic              gen_load;
  logic [ADDR_W-1:0] gen_addr;
  logic              beat_last;
  logic              tile_last;

  // Multiplies live only here and are consumed in S_LOAD; the walk itself is add-only.
  assign row_stride    = ADDR_W'(cw_reg) * ADDR_W'(c_reg);
  assign pix_stride    = ADDR_W'(c_reg);
  assign start_addr    = base_reg + ADDR_W'(row_reg) * row_stride + ADDR_W'(col_reg) * pix_stride;
  assign beats_per_pix = DIM_W'(ceil_div(32'(c_reg), 32'(LANES)));
  assign c_rem         = c_reg % DIM_W'(LANES);
  assign zero_tile     = (h_reg == '0) || (w_reg == '0) || (beats_per_pix == '0);

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_last_strb
      assign last_strb_calc[gi] = (c_rem == '0) || (DIM_W'(gi) < c_rem);
    end
  endgenerate

  assign gen_load = (state_reg == S_LOAD);
  assign fire     = wr.wr_valid && wr.wr_ready;

  skip_fill_addr_gen #(
    .DIM_W  (DIM_W),
    .ADDR_W (ADDR_W),
    .LANES  (LANES)
  ) u_addr_gen (
    .clk           (clk),
    .rst_n         (rst_n),
    .load          (gen_load),
    .advance       (fire),
    .start_addr    (start_addr),
    .row_stride    (row_stride),
    .pix_stride    (pix_stride),
    .tile_h        (h_reg),
    .tile_w        (w_reg),
    .beats_per_pix (beats_per_pix),
    .addr          (gen_addr),
    .beat_last     (beat_last),
    .tile_last     (tile_last)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (skip_start) state_next = S_LOAD;
      S_LOAD:  state_next = zero_tile ? S_DONE : S_WRITE;
      S_WRITE: if (fire && tile_last) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      base_reg      <= '0;
      row_reg       <= '0;
      col_reg       <= '0;
      h_reg         <= '0;
      w_reg         <= '0;
      cw_reg        <= '0;
      c_reg         <= '0;
      fill_reg      <= FILL_VALUE;
      last_strb_reg <= '0;
    end else begin
      state_reg <= state_next;
      // Descriptor is captured only on an accepted start; later input changes are ignored.
      if (state_reg == S_IDLE && skip_start) begin
        base_reg <= out_base_addr;
        row_reg  <= tile_out_row;
        col_reg  <= tile_out_col;
        h_reg    <= tile_out_h;
        w_reg    <= tile_out_w;
        cw_reg   <= cur_out_w;
        c_reg    <= cur_out_c;
        fill_reg <= cfg_fill_value;
      end
      if (state_reg == S_LOAD) begin
        last_strb_reg <= last_strb_calc;
      end
    end
  end

  assign busy        = (state_reg != S_IDLE);
  assign skip_done   = (state_reg == S_DONE);
  assign wr.wr_valid = (state_reg == S_WRITE);
  assign wr.wr_addr  = gen_addr;
  assign wr.wr_data  = {LANES{fill_reg}};
  assign wr.wr_strb  = (state_reg != S_WRITE) ? '0 : (beat_last ? last_strb_reg : '1);

`ifdef TILE_SKIP_FILL_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_tiles <= '0;
      stat_beats <= '0;
    end else begin
      if (skip_done && stat_tiles != '1) stat_tiles <= stat_tiles + 32'd1;
      if (fire && stat_beats != '1)      stat_beats <= stat_beats + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tile_skip_fill.sv
// Directed plus randomized bench for tile_skip_fill; expected beats come from
// the HWC address formula evaluated per element, one line printed per fill.
module tb_tile_skip_fill;

  localparam int DIM_W  = 16;
  localparam int ADDR_W = 32;
  localparam int LANES  = 8;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               skip_start = 1'b0;
  logic               skip_done;
  logic               busy;
  logic [DIM_W-1:0]   tile_out_row = '0;
  logic [DIM_W-1:0]   tile_out_col = '0;
  logic [DIM_W-1:0]   tile_out_h = '0;
  logic [DIM_W-1:0]   tile_out_w = '0;
  logic [DIM_W-1:0]   cur_out_w = '0;
  logic [DIM_W-1:0]   cur_out_c = '0;
  logic [ADDR_W-1:0]  out_base_addr = '0;
  logic [7:0]         cfg_fill_value = '0;
`ifdef TILE_SKIP_FILL_STATS_EN
  logic [31:0]        stat_tiles;
  logic [31:0]        stat_beats;
`endif

  tile_skip_fill_if #(.ADDR_W(ADDR_W), .LANES(LANES)) wr_bus ();

  tile_skip_fill #(.DIM_W(DIM_W), .ADDR_W(ADDR_W), .LANES(LANES)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .skip_start     (skip_start),
    .skip_done      (skip_done),
    .busy           (busy),
    .tile_out_row   (tile_out_row),
    .tile_out_col   (tile_out_col),
    .tile_out_h     (tile_out_h),
    .tile_out_w     (tile_out_w),
    .cur_out_w      (cur_out_w),
    .cur_out_c      (cur_out_c),
    .out_base_addr  (out_base_addr),
    .cfg_fill_value (cfg_fill_value),
    .wr             (wr_bus)
`ifdef TILE_SKIP_FILL_STATS_EN
    ,
    .stat_tiles     (stat_tiles),
    .stat_beats     (stat_beats)
`endif
  );

  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [31:0] exp_addr_q[$];
  logic [7:0]  exp_strb_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Entered and left on a falling edge.
  task automatic run_fill(input string name, input logic [31:0] base,
                          input logic [15:0] row, input logic [15:0] col,
                          input logic [15:0] h, input logic [15:0] w,
                          input logic [15:0] cw, input logic [15:0] c,
                          input int ready_pct, input bit dbl_start, input int abort_at);
    int nb, nexp, k, done_k, first_k, accepted;
    bit aborted;
    logic [7:0]  fill;
    logic [7:0]  strb;
    logic [31:0] a;
    fill = 8'($urandom);
    nb = (int'(c) + LANES - 1) / LANES;
    for (int r = 0; r < int'(h); r++)
      for (int p = 0; p < int'(w); p++)
        for (int b = 0; b < nb; b++) begin
          a = base + (32'(int'(row) + r) * 32'(cw) + 32'(int'(col) + p)) * 32'(c) + 32'(b * LANES);
          strb = ((b == nb - 1) && (int'(c) % LANES != 0)) ? 8'((1 << (int'(c) % LANES)) - 1) : 8'hFF;
          exp_addr_q.push_back(a);
          exp_strb_q.push_back(strb);
        end
    nexp = exp_addr_q.size();

    out_base_addr = base; tile_out_row = row; tile_out_col = col;
    tile_out_h = h; tile_out_w = w; cur_out_w = cw; cur_out_c = c;
    cfg_fill_value = fill; skip_start = 1'b1; wr_bus.wr_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    skip_start = 1'b0;
    out_base_addr = $urandom; tile_out_row = 16'($urandom); tile_out_col = 16'($urandom);
    tile_out_h = 16'($urandom); tile_out_w = 16'($urandom); cur_out_c = 16'($urandom);
    cfg_fill_value = ~fill;
    k = 1;
    check({name, "_busy_n1"}, 64'(busy), 64'(1));
    check({name, "_valid_n1"}, 64'(wr_bus.wr_valid), 64'(0));
    done_k = -1; first_k = -1; accepted = 0; aborted = 1'b0;

    while (k < 4000) begin
      @(posedge clk); @(negedge clk);
      k++;
      skip_start = 1'b0;
      if (abort_at >= 0 && accepted == abort_at) begin
        rst_n = 1'b0;
        #1;
        check({name, "_abort_valid"}, 64'(wr_bus.wr_valid), 64'(0));
        check({name, "_abort_done"}, 64'(skip_done), 64'(0));
        check({name, "_abort_busy"}, 64'(busy), 64'(0));
        aborted = 1'b1;
        break;
      end
      if (skip_done) begin
        done_k = k;
        break;
      end
      if (wr_bus.wr_valid) begin
        if (first_k < 0) first_k = k;
        check({name, "_beat_expected"}, 64'(exp_addr_q.size() > 0), 64'(1));
        if (exp_addr_q.size() > 0) begin
          check({name, "_addr"}, 64'(wr_bus.wr_addr), 64'(exp_addr_q[0]));
          check({name, "_strb"}, 64'(wr_bus.wr_strb), 64'(exp_strb_q[0]));
          check({name, "_data"}, 64'(wr_bus.wr_data), {8{fill}});
          wr_bus.wr_ready = ($urandom_range(99) < 32'(ready_pct));
          if (wr_bus.wr_ready) begin
            void'(exp_addr_q.pop_front());
            void'(exp_strb_q.pop_front());
            accepted++;
          end
        end else begin
          wr_bus.wr_ready = 1'b1;
        end
      end else begin
        wr_bus.wr_ready = 1'b0;
      end
      if (dbl_start && k == 3) skip_start = 1'b1;
    end

    if (aborted) begin
      repeat (3) begin
        @(posedge clk); @(negedge clk);
        check({name, "_rst_valid"}, 64'(wr_bus.wr_valid), 64'(0));
        check({name, "_rst_done"}, 64'(skip_done), 64'(0));
      end
      rst_n = 1'b1;
      wr_bus.wr_ready = 1'b0;
      @(posedge clk); @(negedge clk);
      check({name, "_idle_after_rst"}, 64'(busy), 64'(0));
      $display("fill %s aborted after %0d beats", name, accepted);
    end else begin
      check({name, "_done_seen"}, 64'(done_k > 0), 64'(1));
      check({name, "_beats_left"}, 64'(exp_addr_q.size()), 64'(0));
      if (nexp > 0) check({name, "_first_beat_cycle"}, 64'(first_k), 64'(2));
      if (ready_pct >= 100 || nexp == 0) check({name, "_done_cycle"}, 64'(done_k), 64'(2 + nexp));
      check({name, "_busy_at_done"}, 64'(busy), 64'(1));
      check({name, "_valid_at_done"}, 64'(wr_bus.wr_valid), 64'(0));
      wr_bus.wr_ready = 1'b0;
      repeat (3) begin
        @(posedge clk); @(negedge clk);
        check({name, "_done_once"}, 64'(skip_done), 64'(0));
        check({name, "_idle_after"}, 64'(busy), 64'(0));
      end
      $display("fill %s base=%h row=%0d col=%0d h=%0d w=%0d C=%0d beats=%0d done_at=N+%0d",
               name, base, row, col, h, w, c, nexp, done_k);
    end
    exp_addr_q.delete();
    exp_strb_q.delete();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    wr_bus.wr_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_done", 64'(skip_done), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_valid", 64'(wr_bus.wr_valid), 64'(0));
    check("rst_addr", 64'(wr_bus.wr_addr), 64'(0));
    check("rst_strb", 64'(wr_bus.wr_strb), 64'(0));
    check("rst_data", 64'(wr_bus.wr_data), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    run_fill("t1", 32'h1000, 16'd1, 16'd2, 16'd2, 16'd2, 16'd8, 16'd16, 100, 1'b0, -1);
    run_fill("t2", 32'h0, 16'd0, 16'd0, 16'd1, 16'd1, 16'd5, 16'd12, 100, 1'b0, -1);
    run_fill("t3", 32'h1000, 16'd1, 16'd2, 16'd2, 16'd2, 16'd8, 16'd16, 50, 1'b0, -1);
    run_fill("t4", 32'h1000, 16'd1, 16'd2, 16'd0, 16'd2, 16'd8, 16'd16, 100, 1'b0, -1);
    run_fill("t5", 32'h1000, 16'd1, 16'd2, 16'd2, 16'd2, 16'd8, 16'd16, 100, 1'b1, -1);
    run_fill("t6a", 32'h1000, 16'd1, 16'd2, 16'd2, 16'd2, 16'd8, 16'd16, 100, 1'b0, 3);
    run_fill("t6b", 32'h1000, 16'd1, 16'd2, 16'd2, 16'd2, 16'd8, 16'd16, 100, 1'b0, -1);

    for (int i = 0; i < 16; i++) begin
      run_fill("rnd", $urandom,
               16'($urandom_range(0, 5)), 16'($urandom_range(0, 5)),
               16'($urandom_range(0, 3)), 16'($urandom_range(0, 3)),
               16'($urandom_range(1, 12)), 16'($urandom_range(1, 20)),
               int'($urandom_range(30, 100)), 1'b0, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
